reg_pipe: RTL and testbench

REG_PIPE -- requirements
Module: reg_pipe

---
 rtl/reg_pipe_if.sv | 30 +++
 rtl/reg_pipe.sv | 44 ++++
 tb/tb_reg_pipe.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/reg_pipe_if.sv
// Bus bundle for reg_pipe: stage-0 inputs, stage-(DEPTH-1) outputs and occupancy status.
// DV qualifies D and QV qualifies Q. There is no ready signal; the pipe never back-pressures.
interface reg_pipe_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             ENABLED;
    logic             CLEAR;
    logic [WIDTH-1:0] D;
    logic             DV;
    logic [WIDTH-1:0] Q;
    logic             QV;
    logic [CW-1:0]    COUNT;
    logic             FULL;
    logic             EMPTY;
    // Per-stage valid bits, exposed so checkers can observe occupancy directly
    logic [DEPTH-1:0] stage_valid;

    modport master (
        output ENABLED, CLEAR, D, DV,
        input  Q, QV, COUNT, FULL, EMPTY, stage_valid
    );

    modport slave (
        input  ENABLED, CLEAR, D, DV,
        output Q, QV, COUNT, FULL, EMPTY, stage_valid
    );
endinterface

// File: rtl/reg_pipe.sv
// DEPTH-stage enabled register pipeline with a travelling valid bit and a registered
// occupancy counter; Q/QV come straight from the last stage's registers.
module reg_pipe #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic      CLK,
    input  logic      RESET,
    reg_pipe_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
            valid_q <= '0;
            count_q <= '0;
        end else if (bus.CLEAR) begin
            for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
            valid_q <= '0;
            count_q <= '0;
        end else if (bus.ENABLED) begin
            data_q[0]  <= bus.D;
            valid_q[0] <= bus.DV;
            for (int k = 1; k < DEPTH; k++) begin
                data_q[k]  <= data_q[k-1];
                valid_q[k] <= valid_q[k-1];
            end
            // One in and one out cancel; the counter cannot leave 0..DEPTH
            count_q <= count_q + CW'(bus.DV) - CW'(valid_q[DEPTH-1]);
        end
    end

    assign bus.Q           = data_q[DEPTH-1];
    assign bus.QV          = valid_q[DEPTH-1];
    assign bus.COUNT       = count_q;
    assign bus.FULL        = (count_q == CW'(DEPTH));
    assign bus.EMPTY       = (count_q == '0);
    assign bus.stage_valid = valid_q;
endmodule

// File: tb/tb_reg_pipe.sv
// Self-checking bench for reg_pipe: directed scenarios followed by random traffic,
// all compared against a queue-of-stages reference model.
module tb_reg_pipe;
  localparam int W = 4;
  localparam int N = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Reference: element i holds {valid, data} of stage i
  logic [W:0] mdl[$];

  reg_pipe_if #(.WIDTH(W), .DEPTH(N)) bus ();

  reg_pipe #(.WIDTH(W), .DEPTH(N)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mdl_clear();
    mdl.delete();
    for (int i = 0; i < N; i++) mdl.push_back('0);
  endtask

  task automatic check_all(input string tag);
    int cnt;
    logic [N-1:0] sv;
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      sv[i] = mdl[i][W];
      if (mdl[i][W]) cnt++;
    end
    check({tag, ".q"},     int'(bus.Q), int'(mdl[N-1][W-1:0]));
    check({tag, ".qv"},    int'(bus.QV), int'(mdl[N-1][W]));
    check({tag, ".count"}, int'(bus.COUNT), cnt);
    check({tag, ".full"},  int'(bus.FULL), int'(cnt == N));
    check({tag, ".empty"}, int'(bus.EMPTY), int'(cnt == 0));
    check({tag, ".valid"}, int'(bus.stage_valid), int'(sv));
  endtask

  // Drive one cycle's inputs, advance one rising edge, update the model, settle 1ns
  task automatic step(input logic en, input logic clr, input logic [W-1:0] d, input logic dv);
    bus.ENABLED = en;
    bus.CLEAR   = clr;
    bus.D       = d;
    bus.DV      = dv;
    @(posedge clk);
    if (!rst) begin
      if (clr) mdl_clear();
      else if (en) begin
        mdl.push_front({dv, d});
        void'(mdl.pop_back());
      end
    end
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.ENABLED = 1'b0;
    bus.CLEAR   = 1'b0;
    bus.D       = '0;
    bus.DV      = 1'b0;
    mdl_clear();
    #12;
    check_all("reset");
    check("reset.empty_const", int'(bus.EMPTY), 1);
    rst = 1'b0;

    // Single token: visible on exactly the 4th enabled edge, gone on the 5th
    step(1'b1, 1'b0, 4'hA, 1'b1);
    check("single.cnt1", int'(bus.COUNT), 1);
    for (int e = 2; e <= 5; e++) begin
      step(1'b1, 1'b0, 4'h0, 1'b0);
      check_all($sformatf("single.e%0d", e));
      if (e == 4) begin
        check("single.q_at4", int'(bus.Q), 4'hA);
        check("single.qv_at4", int'(bus.QV), 1);
        check("single.cnt_at4", int'(bus.COUNT), 1);
      end
      if (e == 5) begin
        check("single.qv_at5", int'(bus.QV), 0);
        check("single.cnt_at5", int'(bus.COUNT), 0);
      end
    end

    // Streaming fill: counter saturates at DEPTH while data keeps flowing out
    for (int v = 1; v <= 5; v++) begin
      step(1'b1, 1'b0, W'(v), 1'b1);
      check_all($sformatf("stream.e%0d", v));
    end
    check("stream.full", int'(bus.FULL), 1);
    check("stream.q5", int'(bus.Q), 2);

    // Drain then fill to two, then hold with toggling inputs while disabled
    mdl_clear();
    step(1'b0, 1'b1, 4'h0, 1'b0);
    check_all("flush");
    step(1'b1, 1'b0, 4'h3, 1'b1);
    step(1'b1, 1'b0, 4'h6, 1'b1);
    check("hold.pre_cnt", int'(bus.COUNT), 2);
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b0, W'($urandom_range(0, 15)), c[0]);
      check_all($sformatf("hold.c%0d", c));
    end

    // Full pipe, CLEAR beats ENABLED and discards that cycle's D/DV
    for (int v = 0; v < 4; v++) step(1'b1, 1'b0, W'(9 + v), 1'b1);
    check("clear.pre_full", int'(bus.FULL), 1);
    step(1'b1, 1'b1, 4'hF, 1'b1);
    check_all("clear");
    check("clear.empty", int'(bus.EMPTY), 1);

    // Asynchronous reset between edges with three tokens in flight
    for (int v = 0; v < 3; v++) step(1'b1, 1'b0, W'(v + 4), 1'b1);
    check("areset.pre_cnt", int'(bus.COUNT), 3);
    #3;
    rst = 1'b1;
    mdl_clear();
    #1;
    check_all("areset.now");
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0, 4'h5, 1'b1);
      check_all($sformatf("areset.held%0d", c));
    end
    rst = 1'b0;
    step(1'b1, 1'b0, 4'h7, 1'b1);
    check_all("areset.first");
    check("areset.cnt", int'(bus.COUNT), 1);

    // Random traffic
    for (int c = 0; c < 10000; c++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0),
           W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      check_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
